// File: rtl/rtclock_regs_pkg.sv
// rtclock_regs_pkg
// Shared definitions for the real-time-clock register block and its bench.
// Contents:
//   - register offsets (within a 32-byte window)
//   - AXI response codes
//   - CONTROL bit indices
//   - the per-channel response state type
//   - helpers for the offset decode and the byte-enable merge
package rtclock_regs_pkg;

  localparam logic [4:0] OFF_CONTROL       = 5'h00;
  localparam logic [4:0] OFF_SEC_CONFIG_HI = 5'h08;
  localparam logic [4:0] OFF_SEC_CONFIG_LO = 5'h0C;
  localparam logic [4:0] OFF_SEC_STATE_HI  = 5'h10;
  localparam logic [4:0] OFF_SEC_STATE_LO  = 5'h14;
  localparam logic [4:0] OFF_NSEC_STATE    = 5'h18;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int CTRL_LOAD_BIT   = 0;
  localparam int CTRL_PPS_EN_BIT = 1;

  // Each AXI-Lite channel pair is either waiting for a request or holding a
  // response until the master takes it.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RESP = 1'b1
  } ch_state_t;

  // True for the offsets that exist in the register map. Unaligned offsets
  // inside the window are deliberately treated as unmapped.
  function automatic logic offset_mapped(input logic [4:0] off);
    case (off)
      OFF_CONTROL, OFF_SEC_CONFIG_HI, OFF_SEC_CONFIG_LO,
      OFF_SEC_STATE_HI, OFF_SEC_STATE_LO, OFF_NSEC_STATE: offset_mapped = 1'b1;
      default:                                            offset_mapped = 1'b0;
    endcase
  endfunction

  // Replace only the bytes selected by strb.
  function automatic logic [31:0] apply_strb(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/axi_lite_slave_if.sv
// axi_lite_slave_if
// Generic single-beat AXI4-Lite responder. It owns the handshakes and the
// B/R response registers; the register file behind it only sees strobes.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   aw*/w*/b*, ar*/r*                AXI4-Lite slave channels
//   wr_en, wr_offset, wr_data, wr_strb
//                                    one-cycle write strobe on acceptance
//   wr_err                           from the register file: offset unmapped
//   rd_en, rd_offset                 one-cycle read strobe on acceptance
//   rd_data, rd_err                  from the register file, same cycle
// Requests outside the 32-byte window at BASEADDR are never acknowledged, so
// several responders can share one bus with their outputs OR-combined.
module axi_lite_slave_if
  import rtclock_regs_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASEADDR   = 'h3000_0000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready,
  output logic                    wr_en,
  output logic [4:0]              wr_offset,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic                    wr_err,
  output logic                    rd_en,
  output logic [4:0]              rd_offset,
  input  logic [DATA_WIDTH-1:0]   rd_data,
  input  logic                    rd_err
);

  ch_state_t             wr_state_reg, wr_state_next;
  ch_state_t             rd_state_reg, rd_state_next;
  logic [1:0]            bresp_reg;
  logic [1:0]            rresp_reg;
  logic [DATA_WIDTH-1:0] rdata_reg;
  logic                  aw_match, ar_match;
  logic                  wr_accept, rd_accept;

  assign aw_match = (awaddr[ADDR_WIDTH-1:5] == BASEADDR[ADDR_WIDTH-1:5]);
  assign ar_match = (araddr[ADDR_WIDTH-1:5] == BASEADDR[ADDR_WIDTH-1:5]);

  // Write channel: AW and W are taken on the same edge only once both are
  // present, so neither side is ever accepted on its own.
  always_comb begin
    wr_state_next = wr_state_reg;
    wr_accept     = 1'b0;
    case (wr_state_reg)
      CH_IDLE: if (awvalid && wvalid && aw_match) begin
        wr_accept     = 1'b1;
        wr_state_next = CH_RESP;
      end
      CH_RESP: if (bready) wr_state_next = CH_IDLE;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    rd_accept     = 1'b0;
    case (rd_state_reg)
      CH_IDLE: if (arvalid && ar_match) begin
        rd_accept     = 1'b1;
        rd_state_next = CH_RESP;
      end
      CH_RESP: if (rready) rd_state_next = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_reg <= CH_IDLE;
      rd_state_reg <= CH_IDLE;
      bresp_reg    <= RESP_OKAY;
      rresp_reg    <= RESP_OKAY;
      rdata_reg    <= '0;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
      if (wr_accept) begin
        bresp_reg <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid && bready) begin
        bresp_reg <= RESP_OKAY;
      end
      // Response data is cleared on handshake so RDATA is 0 while idle.
      if (rd_accept) begin
        rdata_reg <= rd_err ? '0 : rd_data;
        rresp_reg <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid && rready) begin
        rdata_reg <= '0;
        rresp_reg <= RESP_OKAY;
      end
    end
  end

  assign awready   = wr_accept;
  assign wready    = wr_accept;
  assign bvalid    = (wr_state_reg == CH_RESP);
  assign bresp     = bresp_reg;
  assign arready   = rd_accept;
  assign rvalid    = (rd_state_reg == CH_RESP);
  assign rresp     = rresp_reg;
  assign rdata     = rdata_reg;

  assign wr_en     = wr_accept;
  assign wr_offset = awaddr[4:0];
  assign wr_data   = wdata;
  assign wr_strb   = wstrb;
  assign rd_en     = rd_accept;
  assign rd_offset = araddr[4:0];

endmodule

// File: rtl/rtclock_axi_regs.sv
// rtclock_axi_regs
// Real-time-clock register file on AXI4-Lite.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN      clock, asynchronous active-low reset
//   S_AXI_*                        AXI4-Lite slave port (32-bit data)
//   sec, nsec                      running time from the rtclock core
//   sec_config                     value the core loads into its seconds counter
//   load                           one-cycle strobe: load sec_config at next pps
//   pps_en                         enables pps-driven loading in the core
// Reading SEC_STATE_HI freezes {sec, nsec} so that the following LO and NSEC
// reads describe the same instant.
module rtclock_axi_regs
  import rtclock_regs_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [31:0] C_BASEADDR         = 32'h3000_0000
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  input  logic [47:0]                       sec,
  input  logic [29:0]                       nsec,
  output logic [63:0]                       sec_config,
  output logic                              load,
  output logic                              pps_en
);

  logic                            wr_en, rd_en, wr_err, rd_err;
  logic [4:0]                      wr_offset, rd_offset;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data, rd_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;

  logic [63:0] sec_config_reg;
  logic        load_reg;
  logic        pps_en_reg;
  logic [47:0] snap_sec_reg;
  logic [29:0] snap_nsec_reg;

  axi_lite_slave_if #(
    .ADDR_WIDTH (C_S_AXI_ADDR_WIDTH),
    .DATA_WIDTH (C_S_AXI_DATA_WIDTH),
    .BASEADDR   (C_S_AXI_ADDR_WIDTH'(C_BASEADDR))
  ) u_if (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .awaddr    (S_AXI_AWADDR),
    .awvalid   (S_AXI_AWVALID),
    .awready   (S_AXI_AWREADY),
    .wdata     (S_AXI_WDATA),
    .wstrb     (S_AXI_WSTRB),
    .wvalid    (S_AXI_WVALID),
    .wready    (S_AXI_WREADY),
    .bresp     (S_AXI_BRESP),
    .bvalid    (S_AXI_BVALID),
    .bready    (S_AXI_BREADY),
    .araddr    (S_AXI_ARADDR),
    .arvalid   (S_AXI_ARVALID),
    .arready   (S_AXI_ARREADY),
    .rdata     (S_AXI_RDATA),
    .rresp     (S_AXI_RRESP),
    .rvalid    (S_AXI_RVALID),
    .rready    (S_AXI_RREADY),
    .wr_en     (wr_en),
    .wr_offset (wr_offset),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_err    (wr_err),
    .rd_en     (rd_en),
    .rd_offset (rd_offset),
    .rd_data   (rd_data),
    .rd_err    (rd_err)
  );

  assign wr_err = !offset_mapped(wr_offset);
  assign rd_err = !offset_mapped(rd_offset);

  // Read mux. SEC_STATE_HI comes straight from the live inputs because the
  // snapshot is captured on the same edge that registers this value.
  always_comb begin
    rd_data = '0;
    case (rd_offset)
      OFF_CONTROL:       rd_data[CTRL_PPS_EN_BIT] = pps_en_reg;
      OFF_SEC_CONFIG_HI: rd_data = sec_config_reg[63:32];
      OFF_SEC_CONFIG_LO: rd_data = sec_config_reg[31:0];
      OFF_SEC_STATE_HI:  rd_data = {16'b0, sec[47:32]};
      OFF_SEC_STATE_LO:  rd_data = snap_sec_reg[31:0];
      OFF_NSEC_STATE:    rd_data = {2'b0, snap_nsec_reg};
      default:           rd_data = '0;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sec_config_reg <= '0;
      load_reg       <= 1'b0;
      pps_en_reg     <= 1'b0;
      snap_sec_reg   <= '0;
      snap_nsec_reg  <= '0;
    end else begin
      load_reg <= 1'b0;
      if (wr_en) begin
        case (wr_offset)
          OFF_CONTROL: if (wr_strb[0]) begin
            load_reg   <= wr_data[CTRL_LOAD_BIT];
            pps_en_reg <= wr_data[CTRL_PPS_EN_BIT];
          end
          OFF_SEC_CONFIG_HI:
            sec_config_reg[63:32] <= apply_strb(sec_config_reg[63:32], wr_data, wr_strb);
          OFF_SEC_CONFIG_LO:
            sec_config_reg[31:0]  <= apply_strb(sec_config_reg[31:0], wr_data, wr_strb);
          default: ;
        endcase
      end
      if (rd_en && (rd_offset == OFF_SEC_STATE_HI)) begin
        snap_sec_reg  <= sec;
        snap_nsec_reg <= nsec;
      end
    end
  end

  assign sec_config = sec_config_reg;
  assign load       = load_reg;
  assign pps_en     = pps_en_reg;

endmodule

// File: tb/tb_rtclock_axi_regs.sv
module tb_rtclock_axi_regs;
  import rtclock_regs_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [47:0] sec;
  logic [29:0] nsec;
  logic [63:0] sec_config;
  logic        load, pps_en;

  rtclock_axi_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (32),
    .C_BASEADDR         (BASE)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .sec           (sec),
    .nsec          (nsec),
    .sec_config    (sec_config),
    .load          (load),
    .pps_en        (pps_en)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int load_cnt = 0;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  // Reference model state, kept as plain values
  logic [63:0] m_cfg;
  logic        m_pps;
  logic [47:0] m_snap_sec;
  logic [29:0] m_snap_nsec;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  function automatic bit in_map(input logic [4:0] off);
    return off inside {5'h00, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18};
  endfunction

  // Every task starts and ends just after a rising edge.
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be,
                           output logic [1:0] resp, output bit ok);
    bit acc = 0;
    ok = 0; resp = 2'bxx;
    awaddr = addr; wdata = data; wstrb = be; awvalid = 1; wvalid = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (awready && wready) begin acc = 1; break; end
    end
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    if (acc) begin
      bready = 1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (bvalid) begin resp = bresp; ok = 1; break; end
      end
      @(posedge clk); #1; bready = 0;
    end
    $display("write addr=%h data=%h strb=%b ok=%0d resp=%b", addr, data, be, ok, resp);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit ok);
    bit acc = 0;
    ok = 0; resp = 2'bxx; data = 'x;
    araddr = addr; arvalid = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (arready) begin acc = 1; break; end
    end
    @(posedge clk); #1; arvalid = 0;
    if (acc) begin
      rready = 1;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (rvalid) begin data = rdata; resp = rresp; ok = 1; break; end
      end
      @(posedge clk); #1; rready = 0;
    end
    $display("read  addr=%h data=%h ok=%0d resp=%b", addr, data, ok, resp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_hs"}, {awready, wready, bvalid, bresp, arready, rvalid, rresp}, 0);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic [63:0] rnd;
    logic [4:0]  offs [8];
    bit          ok;
    int          base_loads;

    offs = '{5'h00, 5'h08, 5'h0C, 5'h10, 5'h14, 5'h18, 5'h1C, 5'h04};
    rst_n = 0; awaddr = 0; wdata = 0; wstrb = 0; awvalid = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0; sec = 48'h1234_5678_9ABC; nsec = 30'd5;

    // Reset state
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_cfg", {sec_config, 2'b00, load, pps_en}, 0);
    @(posedge clk); #1; rst_n = 1;
    @(negedge clk);
    check_idle_outputs("post_reset");
    @(posedge clk); #1;

    // Configure and load
    base_loads = load_cnt;
    axi_write(BASE + 32'h08, 32'd0, 4'hF, resp, ok);   check("cfg_hi_resp", {ok, resp}, {1'b1, RESP_OKAY});
    axi_write(BASE + 32'h0C, 32'd123, 4'hF, resp, ok); check("cfg_lo_resp", {ok, resp}, {1'b1, RESP_OKAY});
    axi_write(BASE + 32'h00, 32'd1, 4'hF, resp, ok);   check("ctrl_resp", {ok, resp}, {1'b1, RESP_OKAY});
    repeat (3) @(posedge clk); #1;
    check("sec_config_123", sec_config, 64'd123);
    check("load_once", load_cnt - base_loads, 1);
    check("pps_en_off", pps_en, 0);
    axi_read(BASE + 32'h08, data, resp, ok); check("rb_cfg_hi", {ok, resp, data}, {1'b1, RESP_OKAY, 32'd0});
    axi_read(BASE + 32'h0C, data, resp, ok); check("rb_cfg_lo", {ok, resp, data}, {1'b1, RESP_OKAY, 32'd123});
    axi_read(BASE + 32'h00, data, resp, ok); check("rb_ctrl", {ok, resp, data}, {1'b1, RESP_OKAY, 32'd0});

    // Coherent snapshot across a seconds rollover into the high word
    sec = 48'h0000_FFFF_FFFF; nsec = 30'd999_999_992;
    axi_read(BASE + 32'h10, data, resp, ok); check("snap_hi", {ok, resp, data}, {1'b1, RESP_OKAY, 32'h0});
    sec = sec + 1; nsec = nsec + 1;
    axi_read(BASE + 32'h14, data, resp, ok); check("snap_lo", {ok, resp, data}, {1'b1, RESP_OKAY, 32'hFFFF_FFFF});
    sec = sec + 1; nsec = nsec + 1;
    axi_read(BASE + 32'h18, data, resp, ok); check("snap_nsec", {ok, resp, data}, {1'b1, RESP_OKAY, 32'd999_999_992});

    // AW ahead of W, then a stalled B channel
    base_loads = load_cnt;
    awaddr = BASE + 32'h0C; wdata = 32'hCAFE_0001; wstrb = 4'hF; awvalid = 1;
    repeat (3) begin
      @(negedge clk); check("aw_only_no_ready", {awready, wready}, 2'b00);
    end
    @(posedge clk); #1; wvalid = 1;
    @(negedge clk); check("aw_w_ready", {awready, wready}, 2'b11);
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    repeat (5) begin
      @(negedge clk); check("b_hold", {bvalid, bresp}, {1'b1, RESP_OKAY});
    end
    check("aw_first_update", sec_config[31:0], 32'hCAFE_0001);
    @(posedge clk); #1; bready = 1;
    @(posedge clk); #1; bready = 0;
    @(negedge clk); check("b_released", bvalid, 0);
    check("aw_first_no_load", load_cnt - base_loads, 0);
    @(posedge clk); #1;

    // Foreign address and unmapped offset
    axi_write(32'h2000_0000, 32'hFFFF_FFFF, 4'hF, resp, ok); check("foreign_wr_ignored", ok, 0);
    check_idle_outputs("foreign_wr");
    axi_read(32'h2000_0008, data, resp, ok); check("foreign_rd_ignored", ok, 0);
    check_idle_outputs("foreign_rd");
    axi_write(BASE + 32'h1C, 32'h1, 4'hF, resp, ok); check("unmapped_wr", {ok, resp}, {1'b1, RESP_SLVERR});
    axi_read(BASE + 32'h1C, data, resp, ok); check("unmapped_rd", {ok, resp, data}, {1'b1, RESP_SLVERR, 32'd0});
    check("unmapped_no_change", sec_config, {32'd0, 32'hCAFE_0001});

    // Byte-enable merge
    axi_write(BASE + 32'h0C, 32'h1122_3344, 4'hF, resp, ok);
    axi_write(BASE + 32'h0C, 32'hAABB_CCDD, 4'b0001, resp, ok);
    axi_read(BASE + 32'h0C, data, resp, ok); check("wstrb_merge", {ok, resp, data}, {1'b1, RESP_OKAY, 32'h1122_33DD});

    // Reset while a read response is held
    araddr = BASE + 32'h14; arvalid = 1; rready = 0;
    @(negedge clk); check("ar_ready_pre_rst", arready, 1);
    @(posedge clk); #1; arvalid = 0;
    @(negedge clk); check("rvalid_held", rvalid, 1);
    #2; rst_n = 0;
    #1; check("rvalid_async_drop", {rvalid, rdata}, 0);
    @(posedge clk); #1; rst_n = 1;
    m_cfg = 0; m_pps = 0; m_snap_sec = 0; m_snap_nsec = 0;
    axi_read(BASE + 32'h00, data, resp, ok); check("rst_ctrl", {ok, data}, {1'b1, 32'd0});
    axi_read(BASE + 32'h08, data, resp, ok); check("rst_cfg_hi", {ok, data}, {1'b1, 32'd0});
    axi_read(BASE + 32'h0C, data, resp, ok); check("rst_cfg_lo", {ok, data}, {1'b1, 32'd0});
    axi_read(BASE + 32'h14, data, resp, ok); check("rst_snap_lo", {ok, data}, {1'b1, 32'd0});
    axi_read(BASE + 32'h18, data, resp, ok); check("rst_snap_nsec", {ok, data}, {1'b1, 32'd0});
    check("rst_outputs", {sec_config, pps_en}, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [4:0]  off;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp_d;
      bit          exp_load;
      rnd  = {$urandom(), $urandom()};
      sec  = rnd[47:0];
      nsec = 30'($urandom_range(0, 999_999_999));
      off  = offs[$urandom_range(0, 7)];
      d    = $urandom();
      be   = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        base_loads = load_cnt;
        exp_load   = (off == 5'h00) && be[0] && d[0];
        case (off)
          5'h00: if (be[0]) m_pps = d[1];
          5'h08: m_cfg[63:32] = merge_bytes(m_cfg[63:32], d, be);
          5'h0C: m_cfg[31:0]  = merge_bytes(m_cfg[31:0], d, be);
          default: ;
        endcase
        axi_write(BASE + 32'(off), d, be, resp, ok);
        check("rnd_wr_resp", {ok, resp}, {1'b1, in_map(off) ? RESP_OKAY : RESP_SLVERR});
        check("rnd_wr_state", {sec_config, pps_en}, {m_cfg, m_pps});
        check("rnd_wr_load", load_cnt - base_loads, exp_load ? 1 : 0);
      end else begin
        case (off)
          5'h00: exp_d = {30'd0, m_pps, 1'b0};
          5'h08: exp_d = m_cfg[63:32];
          5'h0C: exp_d = m_cfg[31:0];
          5'h10: begin
            m_snap_sec = sec; m_snap_nsec = nsec;
            exp_d = {16'd0, m_snap_sec[47:32]};
          end
          5'h14: exp_d = m_snap_sec[31:0];
          5'h18: exp_d = {2'b00, m_snap_nsec};
          default: exp_d = 32'd0;
        endcase
        axi_read(BASE + 32'(off), data, resp, ok);
        check("rnd_rd", {ok, resp, data}, {1'b1, in_map(off) ? RESP_OKAY : RESP_SLVERR, exp_d});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
